qam_demapper_datapath: RTL and testbench
========================================

Name: qam_demapper_datapath

Overview:
- Per-symbol 16-QAM hard-decision demapper datapath; sits after the symbol-rate I/Q front end and before the bit serializer.
- Registers signed 8-bit I/Q samples and slices each axis against 0 and ±threshold.
- Outputs 4 Gray-coded bits per symbol.
- Optional calibration mode derives the slicing threshold from observed peak amplitude.

Parameters:
- W, 8, I/Q sample width (two's complement).
- DEFAULT_THRESH, 64, slicing magnitude threshold after reset (constellation levels ±32, ±96).

Ports:
- symbol_clock  in  1  symbol-rate clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  sample enable; when low all registers hold.
- cal  in  1  calibration mode; peak tracking while high.
- I_in  in  W  signed in-phase sample.
- Q_in  in  W  signed quadrature sample.
- data_out  out  4  demapped symbol bits {I_b1, I_b0, Q_b1, Q_b0}; equals internal register val.
- data_valid  out  1  high when data_out holds a symbol decided from an enabled sample.

Behaviour:
- Reset (rst=0 at a clock edge):
  - I, Q, val, data_valid, peak_cnt and peak all go to 0; thresh goes to DEFAULT_THRESH.
  - Reset has priority over en and cal, including mid-calibration; the partial peak is discarded.
- Stage 1, when en=1: I <= I_in and Q <= Q_in. The registers are named I and Q; verification probes them hierarchically.
- Stage 2, when en=1:
  - val <= {slice(I), slice(Q)}.
  - data_valid <= the stage-1 valid flag. The stage-1 flag is set by any enabled sample and cleared by reset.
- Latency: a sample applied before edge n appears on data_out after edge n+1.
- en=0: all registers hold, including peak tracking; data_out and data_valid are unchanged.
- Axis slice of x against threshold T:
  - Magnitude m = |x|; -128 saturates to 127 (7-bit unsigned).
  - Sign bit b1 = 1 when x >= 0; zero is treated as positive.
  - Inner bit: inner = (m < T); m == T is outer.
  - Gray map: x <= -T gives 00; -T < x < 0 gives 01; 0 <= x < T gives 11; x >= T gives 10.
  - Equivalently b1 = ~sign(x) and b0 = inner.
- Calibration:
  - While en=1 and cal=1: peak <= max(peak, mI, mQ), evaluated each cycle on the registered I/Q magnitudes.
  - On the cycle cal is sampled falling (registered cal_d=1, cal=0): thresh <= (peak*171)>>8, truncated, which approximates 2/3·peak. peak is then cleared.
  - If peak==0 at the falling edge, thresh is unchanged.
  - Slicing continues normally during calibration using the current thresh.
  - The new thresh takes effect for decisions on the cycle after the update.
- Arithmetic:
  - peak*171 uses a 15-bit unsigned product.
  - thresh is 7-bit unsigned; a computed thresh of 0 is forced to 1.
- Simultaneous en=0 and cal falling edge: the edge is detected on the next enabled cycle; cal_d only updates when en=1.

Decomposition:
- Package qam_demapper_pkg:
  - Gray codes OUTER_NEG=2'b00, INNER_NEG=2'b01, INNER_POS=2'b11, OUTER_POS=2'b10.
  - DEFAULT_THRESH, CAL_MULT=171, CAL_SHIFT=8.
- Sub-module qam_axis_slicer:
  - Combinational; inputs x[W] and T[7].
  - Outputs bits[2] and mag[7].
  - Instantiated twice (I and Q).
- Calibration (peak, thresh) and pipeline registers stay in the top module.

Test Plan:
- Reset then apply I=96, Q=96 with en=1 -> after 2 edges data_out=0xA, data_valid=1; I=96 and Q=96 visible after 1 edge.
- Stream (-96,32), (32,-32), (0,64), (-128,-64) on consecutive edges -> data_out 0x3, 0xD, 0xE, 0x0 in order, one per clock.
- Threshold boundary with T=64: I=63 gives 11, I=64 gives 10, I=-64 gives 00, I=-63 gives 01 (Q=0 gives 11) -> data_out 0xF, 0xB, 0x3, 0x7.
- Calibration: cal=1 for 4 samples with max magnitude 60, then cal=0 -> thresh=40. Then I=45, Q=-39 -> data_out=0x9. A calibration with all-zero samples leaves thresh=64.
- en=0 for 3 cycles with changing inputs -> I, Q, data_out, data_valid frozen; resume -> pipeline continues with 2-cycle latency.
- Assert rst=0 mid-stream and mid-calibration -> next edge: data_out=0, data_valid=0, thresh=64; the peak from before reset has no effect after cal falls.

Source files
------------

// File: rtl/qam_demapper_pkg.sv
// Shared constants for the 16-QAM hard-decision demapper: Gray codes,
// threshold widths and the calibration scaling (~2/3 of observed peak).
package qam_demapper_pkg;

   localparam int unsigned T_W            = 7;
   localparam int unsigned PROD_W         = 15;
   localparam int unsigned MAG_MAX        = (1 << T_W) - 1;
   localparam int unsigned DEFAULT_THRESH = 64;
   localparam int unsigned CAL_MULT       = 171;
   localparam int unsigned CAL_SHIFT      = 8;

   localparam logic [1:0] OUTER_NEG = 2'b00;
   localparam logic [1:0] INNER_NEG = 2'b01;
   localparam logic [1:0] INNER_POS = 2'b11;
   localparam logic [1:0] OUTER_POS = 2'b10;

   // thresh = (peak*171)>>8, never allowed to collapse to 0
   function automatic logic [T_W-1:0] cal_thresh(input logic [T_W-1:0] peak);
      logic [PROD_W-1:0] prod;
      logic [T_W-1:0]    t;
      prod = PROD_W'(peak) * PROD_W'(CAL_MULT);
      t    = T_W'(prod >> CAL_SHIFT);
      return (t == '0) ? T_W'(1) : t;
   endfunction

endpackage

// File: rtl/qam_demapper_datapath_slicer.sv
// One-axis 16-QAM slicer: saturated 7-bit magnitude and Gray-coded
// decision of a signed sample against +/-T (zero counts as positive).
module qam_axis_slicer
   import qam_demapper_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic signed [W-1:0]   x,
   input  logic        [T_W-1:0] T,
   output logic        [1:0]     bits,
   output logic        [T_W-1:0] mag
);

   logic [W-1:0] w_abs;
   logic         w_neg;
   logic         w_inner;

   always_comb begin
      w_neg   = x[W-1];
      w_abs   = w_neg ? W'(-x) : W'(x);
      // most-negative input has no positive twin; clamp to the top code
      mag     = (w_abs > W'(MAG_MAX)) ? T_W'(MAG_MAX) : T_W'(w_abs);
      w_inner = (mag < T);
      if (w_neg) begin
         bits = w_inner ? INNER_NEG : OUTER_NEG;
      end else begin
         bits = w_inner ? INNER_POS : OUTER_POS;
      end
   end

endmodule

// File: rtl/qam_demapper_datapath.sv
// 16-QAM hard-decision demapper: two-stage I/Q pipeline with per-axis slicing
// and an optional peak-tracking calibration of the slicing threshold.
module qam_demapper_datapath #(
   parameter int unsigned W              = 8,
   parameter int unsigned DEFAULT_THRESH = qam_demapper_pkg::DEFAULT_THRESH
) (
   input  logic                symbol_clock,
   input  logic                rst,
   input  logic                en,
   input  logic                cal,
   input  logic signed [W-1:0] I_in,
   input  logic signed [W-1:0] Q_in,
   output logic        [3:0]   data_out,
   output logic                data_valid
);

   import qam_demapper_pkg::*;

   logic signed [W-1:0]   I;
   logic signed [W-1:0]   Q;
   logic        [3:0]     val;
   logic                  r_v1;
   logic                  cal_d;
   logic        [T_W-1:0] thresh;
   logic        [T_W-1:0] peak;
   logic        [2:0]     peak_cnt;

   logic [1:0]     w_i_bits;
   logic [1:0]     w_q_bits;
   logic [T_W-1:0] w_i_mag;
   logic [T_W-1:0] w_q_mag;
   logic [T_W-1:0] w_peak_max;
   logic [T_W-1:0] w_thresh_cal;
   logic           w_cal_fall;

   qam_axis_slicer #(.W(W)) u_slice_i (
      .x    (I),
      .T    (thresh),
      .bits (w_i_bits),
      .mag  (w_i_mag)
   );

   qam_axis_slicer #(.W(W)) u_slice_q (
      .x    (Q),
      .T    (thresh),
      .bits (w_q_bits),
      .mag  (w_q_mag)
   );

   // running peak candidate and threshold derived from the stored peak
   always_comb begin
      w_peak_max = peak;
      if (w_i_mag > w_peak_max) w_peak_max = w_i_mag;
      if (w_q_mag > w_peak_max) w_peak_max = w_q_mag;
      w_thresh_cal = cal_thresh(peak);
      w_cal_fall   = cal_d & ~cal;
   end

   always_ff @(posedge symbol_clock) begin
      if (!rst) begin
         I          <= '0;
         Q          <= '0;
         val        <= '0;
         r_v1       <= 1'b0;
         data_valid <= 1'b0;
         cal_d      <= 1'b0;
         thresh     <= T_W'(DEFAULT_THRESH);
         peak       <= '0;
         peak_cnt   <= '0;
      end else if (en) begin
         I          <= I_in;
         Q          <= Q_in;
         val        <= {w_i_bits, w_q_bits};
         r_v1       <= 1'b1;
         data_valid <= r_v1;
         cal_d      <= cal;
         // an all-zero calibration leaves the threshold alone
         if (w_cal_fall) begin
            if (peak != '0) thresh <= w_thresh_cal;
            peak     <= '0;
            peak_cnt <= '0;
         end else if (cal) begin
            peak <= w_peak_max;
            if (peak_cnt != '1) peak_cnt <= peak_cnt + 3'd1;
         end
      end
   end

   assign data_out = val;

endmodule

// File: tb/tb_qam_demapper_datapath.sv
// Bench for qam_demapper_datapath: table vectors and hand sequences feed a
// scoreboard queue that is popped as each decision reaches data_out.
module tb_qam_demapper_datapath;

   logic              symbol_clock = 1'b0;
   logic              rst;
   logic              en;
   logic              cal;
   logic signed [7:0] I_in;
   logic signed [7:0] Q_in;
   logic [3:0]        data_out;
   logic              data_valid;

   int n_tot  = 0;
   int n_pass = 0;

   typedef struct {
      logic signed [7:0] i;
      logic signed [7:0] q;
      logic [3:0]        exp;
   } vec_t;

   typedef struct {
      logic [3:0] exp;
      bit         chk;
      string      nm;
   } sb_t;

   sb_t sb_q[$];

   qam_demapper_datapath #(.W(8), .DEFAULT_THRESH(64)) dut (
      .symbol_clock (symbol_clock),
      .rst          (rst),
      .en           (en),
      .cal          (cal),
      .I_in         (I_in),
      .Q_in         (Q_in),
      .data_out     (data_out),
      .data_valid   (data_valid)
   );

   always #5 symbol_clock = ~symbol_clock;

   task automatic check(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // reference Gray decision for one axis
   function automatic logic [1:0] gray(input int x, input int t);
      if (x <= -t)     return 2'b00;
      else if (x < 0)  return 2'b01;
      else if (x < t)  return 2'b11;
      else             return 2'b10;
   endfunction

   // one clock: drive, push expectation if enabled, pop the one now due
   task automatic step(input logic signed [7:0] i, input logic signed [7:0] q,
                       input bit e, input bit c, input logic [3:0] exp,
                       input bit chk, input string nm);
      sb_t item;
      I_in = i; Q_in = q; en = e; cal = c;
      if (e) begin
         item.exp = exp; item.chk = chk; item.nm = nm;
         sb_q.push_back(item);
      end
      @(posedge symbol_clock); #1;
      if (e && sb_q.size() >= 2) begin
         item = sb_q.pop_front();
         if (item.chk) begin
            check({item.nm, "_data_out"}, int'(data_out), int'(item.exp));
            check({item.nm, "_valid"}, int'(data_valid), 1);
         end
      end
   endtask

   task automatic do_reset(input bit e, input bit c, input string nm);
      rst = 1'b0; en = e; cal = c;
      I_in = 8'sd77; Q_in = -8'sd77;
      @(posedge symbol_clock); #1;
      sb_q.delete();
      check({nm, "_data_out"}, int'(data_out), 0);
      check({nm, "_valid"}, int'(data_valid), 0);
      check({nm, "_thresh"}, int'(dut.thresh), 64);
      check({nm, "_peak"}, int'(dut.peak), 0);
      check({nm, "_I"}, int'(dut.I), 0);
      check({nm, "_Q"}, int'(dut.Q), 0);
      rst = 1'b1;
   endtask

   vec_t tv[9];

   initial begin
      logic signed [7:0] ri;
      logic signed [7:0] rq;

      tv[0] = '{8'sd96,   8'sd96,  4'hA};
      tv[1] = '{-8'sd96,  8'sd32,  4'h3};
      tv[2] = '{8'sd32,  -8'sd32,  4'hD};
      tv[3] = '{8'sd0,    8'sd64,  4'hE};
      tv[4] = '{8'h80,   -8'sd64,  4'h0};
      tv[5] = '{8'sd63,   8'sd0,   4'hF};
      tv[6] = '{8'sd64,   8'sd0,   4'hB};
      tv[7] = '{-8'sd64,  8'sd0,   4'h3};
      tv[8] = '{-8'sd63,  8'sd0,   4'h7};

      rst = 1'b0; en = 1'b0; cal = 1'b0; I_in = '0; Q_in = '0;
      do_reset(1'b0, 1'b0, "reset");

      // basic stream and T=64 boundaries, back to back
      for (int k = 0; k < 9; k++) begin
         step(tv[k].i, tv[k].q, 1'b1, 1'b0, tv[k].exp, 1'b1, $sformatf("vec%0d", k));
         if (k == 0) begin
            check("first_I", int'(dut.I), 96);
            check("first_Q", int'(dut.Q), 96);
            check("first_valid", int'(data_valid), 0);
         end
      end
      step('0, '0, 1'b1, 1'b0, '0, 1'b0, "flush");

      // random samples against the reference slicer
      for (int k = 0; k < 16; k++) begin
         ri = 8'($urandom_range(0, 255));
         rq = 8'($urandom_range(0, 255));
         step(ri, rq, 1'b1, 1'b0, {gray(int'(ri), 64), gray(int'(rq), 64)},
              1'b1, $sformatf("rand%0d", k));
      end
      step('0, '0, 1'b1, 1'b0, '0, 1'b0, "flush");

      // en=0 freezes everything, including peak tracking
      step(8'sd96, -8'sd96, 1'b1, 1'b0, 4'h8, 1'b1, "hold_a");
      step(-8'sd32, 8'sd32, 1'b1, 1'b0, 4'h7, 1'b1, "hold_b");
      for (int k = 0; k < 3; k++) begin
         step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'b0, 1'b1, '0, 1'b0, "idle");
         check("hold_I", int'(dut.I), -32);
         check("hold_Q", int'(dut.Q), 32);
         check("hold_data_out", int'(data_out), 8);
         check("hold_valid", int'(data_valid), 1);
         check("hold_peak", int'(dut.peak), 0);
      end
      step(8'sd32, 8'sd96, 1'b1, 1'b0, 4'hE, 1'b1, "resume_c");
      step('0, '0, 1'b1, 1'b0, '0, 1'b0, "flush");

      // calibration to peak 60 -> thresh 40
      do_reset(1'b1, 1'b0, "cal_rst");
      step(8'sd10,  -8'sd20, 1'b1, 1'b1, 4'hD, 1'b1, "cal_s0");
      step(-8'sd60,  8'sd5,  1'b1, 1'b1, 4'h7, 1'b1, "cal_s1");
      step(8'sd30,   8'sd0,  1'b1, 1'b1, 4'hF, 1'b1, "cal_s2");
      step(8'sd0,  -8'sd50,  1'b1, 1'b1, 4'hD, 1'b1, "cal_s3");
      check("cal_peak", int'(dut.peak), 60);
      step(8'sd0, 8'sd0, 1'b0, 1'b0, '0, 1'b0, "cal_gap");
      check("cal_gap_thresh", int'(dut.thresh), 64);
      check("cal_gap_peak", int'(dut.peak), 60);
      step(8'sd45, -8'sd39, 1'b1, 1'b0, 4'h9, 1'b1, "cal_s4");
      check("cal_thresh", int'(dut.thresh), 40);
      check("cal_peak_clr", int'(dut.peak), 0);
      step('0, '0, 1'b1, 1'b0, '0, 1'b0, "flush");

      // all-zero calibration leaves the default threshold
      do_reset(1'b1, 1'b0, "zc_rst");
      for (int k = 0; k < 3; k++)
         step('0, '0, 1'b1, 1'b1, 4'hF, 1'b1, $sformatf("zc%0d", k));
      step('0, '0, 1'b1, 1'b0, 4'hF, 1'b1, "zc_fall");
      check("zc_thresh", int'(dut.thresh), 64);
      step('0, '0, 1'b1, 1'b0, '0, 1'b0, "flush");

      // peak of 1 computes thresh 0, forced to 1
      do_reset(1'b1, 1'b0, "p1_rst");
      step(8'sd1, 8'sd0, 1'b1, 1'b1, 4'hF, 1'b1, "p1_s0");
      step(8'sd0, 8'sd0, 1'b1, 1'b1, 4'hF, 1'b1, "p1_s1");
      step(8'sd0, 8'sd0, 1'b1, 1'b0, 4'hF, 1'b1, "p1_fall");
      check("p1_thresh", int'(dut.thresh), 1);
      step(-8'sd1, 8'sd1, 1'b1, 1'b0, 4'h2, 1'b1, "p1_edge");
      step('0, '0, 1'b1, 1'b0, '0, 1'b0, "flush");

      // reset mid-stream and mid-calibration discards the partial peak
      for (int k = 0; k < 3; k++)
         step(8'sd100, -8'sd100, 1'b1, 1'b1, 4'h8, 1'b1, $sformatf("mc%0d", k));
      do_reset(1'b1, 1'b1, "mc_rst");
      step('0, '0, 1'b1, 1'b1, 4'hF, 1'b1, "mc_s0");
      check("mc_valid_after_rst", int'(data_valid), 0);
      step('0, '0, 1'b1, 1'b1, 4'hF, 1'b1, "mc_s1");
      step('0, '0, 1'b1, 1'b0, 4'hF, 1'b1, "mc_fall");
      check("mc_thresh", int'(dut.thresh), 64);
      step(8'sd63, -8'sd64, 1'b1, 1'b0, 4'hC, 1'b1, "mc_s2");
      step('0, '0, 1'b1, 1'b0, '0, 1'b0, "flush");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
